seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response channel of seq_alu: valid/ready request with operands,
// valid/ready result with zero and illegal flags.
interface seq_alu_if #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [OP_WIDTH-1:0] op;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    res;
  logic                zero;
  logic                illegal;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, res, zero, illegal
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, res, zero, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential integer ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add
// multiply and WIDTH-cycle restoring divide, behind a valid/ready handshake.
module seq_alu #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 5
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_COPY1  = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_COPY2  = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(17);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(18);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(19);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(20);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [OP_WIDTH-1:0] op,
                                              input logic [WIDTH-1:0]    a,
                                              input logic [WIDTH-1:0]    b);
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] r;
    sh = b[SH_W-1:0];
    r  = '0;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SRA:   r = $signed(a) >>> sh;
      OP_SLT:   r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_COPY1: r = a;
      OP_COPY2: r = b;
      OP_JALR: begin
        r    = a + b;
        r[0] = 1'b0;
      end
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_mul_op(input logic [OP_WIDTH-1:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [OP_WIDTH-1:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  state_e              state_q;
  logic                out_valid_q;
  logic                zero_q;
  logic                illegal_q;
  logic [WIDTH-1:0]    res_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [OP_WIDTH-1:0] op_q;
  logic [WIDTH-1:0]    a_q;
  logic                neg_q;
  logic                rneg_q;
  logic                dz_q;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [2*WIDTH-1:0]  prod_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [WIDTH-1:0]    rem_q;
  logic [WIDTH-1:0]    dvd_q;
  logic [WIDTH-1:0]    dvs_q;

  logic                accept;
  logic                a_neg_d;
  logic                b_neg_d;
  logic [WIDTH-1:0]    a_mag_d;
  logic [WIDTH-1:0]    b_mag_d;
  logic [WIDTH-1:0]    alu_res_d;
  logic [2*WIDTH-1:0]  prod_d;
  logic [2*WIDTH-1:0]  prod_fix_d;
  logic [WIDTH-1:0]    mul_res_d;
  logic [WIDTH:0]      trial_d;
  logic                ge_d;
  logic [WIDTH-1:0]    rem_d;
  logic [WIDTH-1:0]    quo_d;
  logic [WIDTH-1:0]    div_res_d;

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  // Operand magnitudes: the iterative units always work unsigned, sign is fixed at the end
  always_comb begin
    a_neg_d   = 1'b0;
    b_neg_d   = 1'b0;
    if ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) || (bus.op == OP_DIV) || (bus.op == OP_REM))
      a_neg_d = bus.a[WIDTH-1];
    if ((bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM))
      b_neg_d = bus.b[WIDTH-1];
    a_mag_d   = a_neg_d ? -bus.a : bus.a;
    b_mag_d   = b_neg_d ? -bus.b : bus.b;
    alu_res_d = alu_fn(bus.op, bus.a, bus.b);
  end

  always_comb begin
    prod_d     = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_fix_d = neg_q ? -prod_d : prod_d;
    mul_res_d  = (op_q == OP_MUL) ? prod_fix_d[WIDTH-1:0] : prod_fix_d[2*WIDTH-1:WIDTH];

    trial_d    = {rem_q, dvd_q[WIDTH-1]};
    ge_d       = trial_d >= {1'b0, dvs_q};
    rem_d      = ge_d ? (trial_d[WIDTH-1:0] - dvs_q) : trial_d[WIDTH-1:0];
    quo_d      = {dvd_q[WIDTH-2:0], ge_d};
    div_res_d  = '0;
    if ((op_q == OP_DIV) || (op_q == OP_DIVU))
      div_res_d = dz_q ? '1 : (neg_q ? -quo_d : quo_d);
    else
      div_res_d = dz_q ? a_q : (rneg_q ? -rem_d : rem_d);
  end

  // Iteration datapath: loaded on accept, stepped once per cycle in MUL/DIV
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= bus.op;
      a_q      <= bus.a;
      dz_q     <= (bus.b == '0);
      neg_q    <= a_neg_d ^ b_neg_d;
      rneg_q   <= a_neg_d;
      mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
      mplier_q <= b_mag_d;
      prod_q   <= '0;
      rem_q    <= '0;
      dvd_q    <= a_mag_d;
      dvs_q    <= b_mag_d;
    end else if (state_q == MUL) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end else if (state_q == DIV) begin
      rem_q    <= rem_d;
      dvd_q    <= quo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            cnt_q <= '0;
            if (is_mul_op(bus.op)) begin
              state_q     <= MUL;
              out_valid_q <= 1'b0;
            end else if (is_div_op(bus.op)) begin
              state_q     <= DIV;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              res_q       <= alu_res_d;
              zero_q      <= (alu_res_d == '0);
              illegal_q   <= (bus.op > OP_REMU);
            end
          end else if ((state_q == DONE) && bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= mul_res_d;
            zero_q      <= (mul_res_d == '0);
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
          end
        end
        DIV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= div_res_d;
            zero_q      <= (div_res_d == '0);
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu (WIDTH=32) against a plain
// 64-bit arithmetic reference model, plus directed corner cases.
module tb_seq_alu;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W), .OP_WIDTH(5)) bus();

  seq_alu #(.WIDTH(W), .OP_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns {illegal, res} from the arithmetic definition of each op.
  function automatic logic [32:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    logic [4:0]      sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = b[4:0];
    r  = '0;
    p  = '0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = a << sh;
      6:  r = a >> sh;
      7:  begin p = sa >>> sh; r = p[31:0]; end
      8:  r = (sa < sb) ? 32'd1 : 32'd0;
      9:  r = (ua < ub) ? 32'd1 : 32'd0;
      10: r = a;
      11: r = b;
      12: r = (a + b) & 32'hFFFF_FFFE;
      13: begin p = ua * ub; r = p[31:0]; end
      14: begin p = sa * sb; r = p[63:32]; end
      15: begin p = sa * longint'(ub); r = p[63:32]; end
      16: begin p = ua * ub; r = p[63:32]; end
      17: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      18: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      19: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      20: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
      default: return {1'b1, 32'b0};
    endcase
    return {1'b0, r};
  endfunction

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    logic [32:0] e;
    int          lat, wt, exp_lat;
    e       = model(int'(op), a, b);
    exp_lat = (op >= 13 && op <= 20) ? W + 1 : 1;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    wt = 0;
    while (!bus.in_ready && wt < 100) begin
      @(posedge clk); #1; wt++;
    end
    if (wt >= 100) begin
      check({tag, "_in_ready_timeout"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"},     64'(bus.res), 64'(e[31:0]));
    check({tag, "_zero"},    64'(bus.zero), 64'(e[31:0] == 0));
    check({tag, "_illegal"}, 64'(bus.illegal), 64'(e[32]));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [31:0] held;
    logic [4:0]  rop;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_res",       64'(bus.res), 64'd0);
    check("rst_zero",      64'(bus.zero), 64'd1);
    check("rst_illegal",   64'(bus.illegal), 64'd0);
    rst = 1'b0;
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);

    send(5'd8,  32'hFFFF_FFFF, 32'd1, "slt");
    check("slt_const", 64'(bus.res), 64'd1);
    send(5'd9,  32'hFFFF_FFFF, 32'd1, "sltu");
    check("sltu_const", 64'(bus.zero), 64'd1);
    send(5'd14, 32'h8000_0000, 32'h8000_0000, "mulh");
    check("mulh_const", 64'(bus.res), 64'h4000_0000);
    send(5'd13, 32'h8000_0000, 32'h8000_0000, "mul");
    send(5'd17, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_const", 64'(bus.res), 64'hFFFF_FFFD);
    send(5'd19, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    send(5'd18, 32'd5, 32'd0, "divu_by0");
    send(5'd20, 32'd5, 32'd0, "remu_by0");
    send(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    send(5'd19, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    send(5'd31, 32'd7, 32'd9, "illegal31");
    send(5'd5,  32'd1, 32'h21, "sll_mask");
    check("sll_const", 64'(bus.res), 64'd2);

    // Stall in DONE, then back-to-back accept on the releasing edge
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(5'd0, 32'd10, 32'd20, "hold_add");
    held = bus.res;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res",       64'(bus.res), 64'(held));
      check("hold_in_ready",  64'(bus.in_ready), 64'd0);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    send(5'd0, 32'd2, 32'd3, "b2b_add");

    // Abort a divide with reset
    @(posedge clk); #1;
    bus.op = 5'd18; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    send(5'd0, 32'd1, 32'd1, "after_abort_add");

    // Reset wins over a same-edge accept
    bus.op = 5'd0; bus.a = 32'd4; bus.b = 32'd4; bus.in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    check("rst_drop_ov0", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("rst_drop_ov1", 64'(bus.out_valid), 64'd0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) rop = 5'($urandom_range(21, 31));
      else                           rop = 5'($urandom_range(0, 20));
      send(rop, pick(), pick(), $sformatf("rnd%0d_op%0d", n, rop));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
